// File: rtl/mips_prog_loader.sv
// Program loader / run controller: streams words into imem (1 write per handshake, 1-cycle latency), holds core reset,
// then runs until PC stalls or the cycle budget expires. in_ready drops after last/overflow word. `LOADER_PAD_NOP_EN pads imem tail with NOPs.
module mips_prog_loader #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16,
   parameter int DEPTH       = 256,
   parameter int HOLD_CYCLES = 10,
   parameter int STALL_LIMIT = 8,
   parameter int CYC_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_data,
   input  logic                   in_last,
   output logic                   imem_we,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_wdata,
   output logic                   core_rst,
   input  logic [PC_WIDTH-1:0]    core_pc,
   output logic                   done,
   output logic [1:0]             done_reason,
   output logic                   ovf,
   output logic [PC_WIDTH:0]      word_count,
   output logic [CYC_WIDTH-1:0]   run_cycles
);
   localparam int CNT_W   = PC_WIDTH + 1;
   localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0]     LAST_PTR  = CNT_W'(DEPTH - 1);
   localparam logic [HOLD_W-1:0]    HOLD_END  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STALL_W-1:0]   STALL_END = STALL_W'(STALL_LIMIT - 1);
   localparam logic [CYC_WIDTH-1:0] CYC_MAX   = '1;

   typedef enum logic [2:0] {IDLE, LOAD, PAD, HOLD, RUN, DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     ptr;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [STALL_W-1:0]   stall_cnt;
   logic [PC_WIDTH-1:0]  prev_pc;
   logic                 first_run;

   logic                 handshake;
   logic                 at_end;
   logic [STALL_W-1:0]   stall_next;
   logic [CYC_WIDTH-1:0] run_next;
   logic                 stall_hit;
   logic                 cyc_hit;

   // The first RUN cycle has no previous PC to compare against.
   always_comb begin
      handshake  = in_valid & in_ready;
      at_end     = (ptr == LAST_PTR);
      stall_next = (!first_run && core_pc == prev_pc) ? stall_cnt + 1'b1 : '0;
      run_next   = (run_cycles == CYC_MAX) ? run_cycles : run_cycles + 1'b1;
      stall_hit  = (stall_next == STALL_END);
      cyc_hit    = (run_next == CYC_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         core_rst    <= 1'b1;
         in_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         done        <= 1'b0;
         done_reason <= 2'b00;
         ovf         <= 1'b0;
         word_count  <= '0;
         run_cycles  <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         stall_cnt   <= '0;
         prev_pc     <= '0;
         first_run   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= LOAD;
                  in_ready    <= 1'b1;
                  ptr         <= '0;
                  word_count  <= '0;
                  ovf         <= 1'b0;
                  done        <= 1'b0;
                  done_reason <= 2'b00;
                  run_cycles  <= '0;
               end
            end
            LOAD: begin
               if (handshake) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr[PC_WIDTH-1:0];
                  imem_wdata <= in_data;
                  ptr        <= ptr + 1'b1;
                  word_count <= word_count + 1'b1;
                  // Filling the last slot without in_last means the program did not fit.
                  if (in_last || at_end) begin
                     in_ready <= 1'b0;
                     ovf      <= !in_last;
                     hold_cnt <= '0;
`ifdef LOADER_PAD_NOP_EN
                     state    <= at_end ? HOLD : PAD;
`else
                     state    <= HOLD;
`endif
                  end
               end
            end
`ifdef LOADER_PAD_NOP_EN
            PAD: begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr[PC_WIDTH-1:0];
               imem_wdata <= '0;
               ptr        <= ptr + 1'b1;
               if (at_end) state <= HOLD;
            end
`endif
            HOLD: begin
               if (hold_cnt == HOLD_END) begin
                  state     <= RUN;
                  core_rst  <= 1'b0;
                  first_run <= 1'b1;
                  stall_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RUN: begin
               run_cycles <= run_next;
               stall_cnt  <= stall_next;
               prev_pc    <= core_pc;
               first_run  <= 1'b0;
               if (stall_hit || cyc_hit) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  core_rst    <= 1'b1;
                  done_reason <= stall_hit ? 2'b01 : 2'b10;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: three instances (default, small DEPTH/CYC_WIDTH, DEPTH=8 for padding).
module tb_mips_prog_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [15:0] in_data = '0;
   logic [7:0]  core_pc = '0;
   logic        start [3];
   logic        rdy [3];
   logic        we [3];
   logic        crst [3];
   logic        dn [3];
   logic        ov [3];
   logic [7:0]  addr [3];
   logic [15:0] wdat [3];
   logic [1:0]  rsn [3];
   logic [8:0]  wc [3];
   logic [15:0] rc0;
   logic [3:0]  rc1;
   logic [15:0] rc2;

   int n_vec = 0;
   int n_err = 0;
   int hs, nwr, runc, k, rel;
   logic hs_now, aw;

   mips_prog_loader u_a (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .in_last(in_last), .imem_we(we[0]), .imem_addr(addr[0]),
      .imem_wdata(wdat[0]), .core_rst(crst[0]), .core_pc(core_pc), .done(dn[0]),
      .done_reason(rsn[0]), .ovf(ov[0]), .word_count(wc[0]), .run_cycles(rc0)
   );

   mips_prog_loader #(.DEPTH(4), .HOLD_CYCLES(3), .CYC_WIDTH(4)) u_b (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .in_last(in_last), .imem_we(we[1]), .imem_addr(addr[1]),
      .imem_wdata(wdat[1]), .core_rst(crst[1]), .core_pc(core_pc), .done(dn[1]),
      .done_reason(rsn[1]), .ovf(ov[1]), .word_count(wc[1]), .run_cycles(rc1)
   );

   mips_prog_loader #(.DEPTH(8), .HOLD_CYCLES(2)) u_c (
      .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .in_last(in_last), .imem_we(we[2]), .imem_addr(addr[2]),
      .imem_wdata(wdat[2]), .core_rst(crst[2]), .core_pc(core_pc), .done(dn[2]),
      .done_reason(rsn[2]), .ovf(ov[2]), .word_count(wc[2]), .run_cycles(rc2)
   );

   typedef struct {
      logic        r, s, vl;
      logic [15:0] d;
      logic        l;
      logic [7:0]  pc;
      logic        e_rdy, e_we;
      logic [7:0]  e_addr;
      logic [15:0] e_wdat;
      logic        e_crst, e_done;
      logic [1:0]  e_rsn;
      logic [8:0]  e_wc;
      logic [15:0] e_run;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input logic vl, input logic [15:0] d,
                               input logic l, input logic [7:0] pc, input logic erdy, input logic ewe,
                               input logic [7:0] ea, input logic [15:0] ed, input logic ecr,
                               input logic edn, input logic [1:0] ers, input logic [8:0] ewc,
                               input logic [15:0] erun);
      vec_t t;
      t.r = r; t.s = s; t.vl = vl; t.d = d; t.l = l; t.pc = pc;
      t.e_rdy = erdy; t.e_we = ewe; t.e_addr = ea; t.e_wdat = ed; t.e_crst = ecr;
      t.e_done = edn; t.e_rsn = ers; t.e_wc = ewc; t.e_run = erun;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;

      // Reset, then load 0x1111..0x4444, hold 10 cycles, halt on a stable PC.
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,0,1,0,0,0,0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1,0,1,16'(16'h1111*(i+1)),(i==3),0, (i!=3),1,8'(i),16'(16'h1111*(i+1)),1,0,0,9'(i+1),0));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,0,4,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,4,0));
      tbl.push_back(mk(1,0,0,0,0,8'h03, 0,0,0,0,0,0,0,4,1));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1,0,0,0,0,8'h05, 0,0,0,0,0,0,0,4,16'(i+2)));
      tbl.push_back(mk(1,0,0,0,0,8'h05, 0,0,0,0,1,1,2'b01,4,9));
      tbl.push_back(mk(1,0,0,0,0,8'h05, 0,0,0,0,1,1,2'b01,4,9));
      // Restart from DONE with a single-word program.
      tbl.push_back(mk(1,1,0,0,0,8'h05, 1,0,0,0,1,0,0,0,0));
      tbl.push_back(mk(1,0,1,16'hABCD,1,0, 0,1,0,16'hABCD,1,0,0,1,0));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,1,0));
      tbl.push_back(mk(1,0,0,0,0,8'h01, 0,0,0,0,0,0,0,1,1));
      tbl.push_back(mk(1,0,0,0,0,8'h02, 0,0,0,0,0,0,0,1,2));
      tbl.push_back(mk(1,1,0,0,0,8'h03, 0,0,0,0,0,0,0,1,3));
      // Reset in the middle of RUN.
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,0,0,0,0,8'h03, 0,0,0,0,1,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,0,0,0));

      foreach (tbl[i]) begin
         rst      = tbl[i].r;
         start[0] = tbl[i].s;
         in_valid = tbl[i].vl;
         in_data  = tbl[i].d;
         in_last  = tbl[i].l;
         core_pc  = tbl[i].pc;
         @(posedge clk); #1;
         aw = tbl[i].e_we || !tbl[i].r;
         chk($sformatf("vec%0d", i),
             {rdy[0], we[0], aw ? addr[0] : 8'h00, aw ? wdat[0] : 16'h0000, crst[0], dn[0], rsn[0], ov[0], wc[0], rc0},
             {tbl[i].e_rdy, tbl[i].e_we, aw ? tbl[i].e_addr : 8'h00, aw ? tbl[i].e_wdat : 16'h0000,
              tbl[i].e_crst, tbl[i].e_done, tbl[i].e_rsn, 1'b0, tbl[i].e_wc, tbl[i].e_run});
      end
      start[0] = 1'b0; in_valid = 1'b0; in_last = 1'b0; core_pc = '0;

      // Overflow (DEPTH=4, 6 words offered, no in_last) followed by timeout (CYC_WIDTH=4).
      start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      chk("b_ready_after_start", rdy[1], 1);
      in_valid = 1'b1; in_data = 16'hB000;
      hs = 0; nwr = 0; runc = 0;
      for (int c = 0; c < 60 && !dn[1]; c++) begin
         hs_now  = in_valid && rdy[1];
         core_pc = core_pc + 8'd1;
         @(posedge clk); #1;
         if (hs_now) begin
            hs++;
            in_data = 16'hB000 + 16'(hs);
            if (hs == 4) chk("b_ready_low_after_ovf", rdy[1], 0);
         end
         if (c == 8) in_valid = 1'b0;
         if (we[1]) begin
            chk($sformatf("b_wr%0d_addr", nwr), addr[1], nwr);
            chk($sformatf("b_wr%0d_data", nwr), wdat[1], 32'hB000 + nwr);
            nwr++;
         end
         if (!crst[1]) runc++;
      end
      in_valid = 1'b0;
      chk("b_done", dn[1], 1);
      chk("b_reason", rsn[1], 2'b10);
      chk("b_run_cycles", rc1, 15);
      chk("b_run_span", runc, 15);
      chk("b_writes", nwr, 4);
      chk("b_accepted", hs, 4);
      chk("b_ovf", ov[1], 1);
      chk("b_word_count", wc[1], 4);

      // DEPTH=8, 3-word program: tail padding only when the feature is built in.
      start[2] = 1'b1;
      @(posedge clk); #1;
      start[2] = 1'b0;
      nwr = 0; k = 0; rel = 0;
      for (int c = 0; c < 24; c++) begin
         in_valid = (c < 3);
         in_data  = 16'hC001 + 16'(c);
         in_last  = (c == 2);
         @(posedge clk); #1;
         if (we[2]) begin
            chk($sformatf("c_wr%0d_addr", nwr), addr[2], nwr);
            chk($sformatf("c_wr%0d_data", nwr), wdat[2], (nwr < 3) ? (32'hC001 + nwr) : 0);
            nwr++;
         end
         if (c >= 2) k++;
         if (!crst[2] && rel == 0) rel = k;
      end
      in_valid = 1'b0; in_last = 1'b0;
`ifdef LOADER_PAD_NOP_EN
      chk("c_writes", nwr, 8);
      chk("c_release", rel, 8);
`else
      chk("c_writes", nwr, 3);
      chk("c_release", rel, 3);
`endif
      chk("c_word_count", wc[2], 3);
      chk("c_ovf", ov[2], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Synthesizable program loader and run controller for the MIPS16 chip-verification environment. It accepts a stream of instruction words over a valid/ready handshake, writes them into the DUV instruction memory, holds the core in reset for a parametrised number of cycles, then releases it and watches the PC for halt or timeout. It generalises the bench's fixed 10-cycle reset task and hand-loaded instruction array into a reusable, parametrised hardware block.

## Interface
- PC_WIDTH, 8, instruction-memory address / core PC width
- INSTR_WIDTH, 16, instruction word width
- DEPTH, 256, instruction-memory words (≤ 2**PC_WIDTH)
- HOLD_CYCLES, 10, core reset cycles after load completes (≥ 1)
- STALL_LIMIT, 8, consecutive cycles of unchanged PC that count as halt (≥ 2)
- CYC_WIDTH, 16, run-cycle counter width; timeout at 2**CYC_WIDTH-1 cycles
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins load from IDLE or DONE
- in_valid  input  1  instruction word valid
- in_ready  output  1  loader can accept a word
- in_data  input  INSTR_WIDTH  instruction word
- in_last  input  1  final word of program
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  PC_WIDTH  write address
- imem_wdata  output  INSTR_WIDTH  write data
- core_rst  output  1  DUV reset, active-high
- core_pc  input  PC_WIDTH  DUV program counter
- done  output  1  run finished
- done_reason  output  2  01 halt, 10 timeout, 00 none
- ovf  output  1  program exceeded DEPTH
- word_count  output  PC_WIDTH+1  words written this load
- run_cycles  output  CYC_WIDTH  cycles core spent out of reset

## Operation
- States: IDLE, LOAD, PAD (macro only), HOLD, RUN, DONE.
- Reset (rst=0 at posedge): state IDLE; core_rst=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; done_reason=00; ovf=0; word_count=0; run_cycles=0. Reset mid-operation aborts immediately; partially written memory is not cleared.
- IDLE: core_rst=1; start → LOAD, clears word_count, ovf, done, done_reason, run_cycles, write pointer.
- LOAD: in_ready=1; each handshake (in_valid & in_ready) writes word at pointer, pointer and word_count +1. Handshake with in_last → PAD (if enabled) else HOLD. Handshake at pointer DEPTH-1 without in_last → ovf=1, same exit; further words refused (in_ready=0).
- HOLD: core_rst=1 for exactly HOLD_CYCLES cycles, then RUN.
- RUN: core_rst=0; run_cycles +1 per cycle (saturating). Stall counter +1 when core_pc equals previous-cycle core_pc, else cleared; compare starts on second RUN cycle. Stall counter reaching STALL_LIMIT-1 → DONE, reason 01. run_cycles reaching 2**CYC_WIDTH-1 → DONE, reason 10. Both same cycle → 01.
- DONE: done=1, core_rst=1, reason and counters held; start → LOAD (clears as from IDLE). start ignored in LOAD, PAD, HOLD, RUN.

## Timing
- Write outputs registered: handshake at edge N → imem_we=1 with addr/data during cycle N+1, exactly one cycle per word; back-to-back words stream at one per cycle.
- in_ready deasserts the cycle after the last/overflow handshake.
- Last handshake at edge N → first HOLD cycle N+1 (N+1+PAD words with macro); core_rst falls HOLD_CYCLES cycles later.
- done and done_reason registered, asserted the cycle after the terminating condition; core_rst rises that same cycle.

## Configuration
- LOADER_PAD_NOP_EN defined: PAD state writes 0 (NOP) to every address from pointer to DEPTH-1, one per cycle, in_ready=0, word_count unchanged; then HOLD. Skipped when ovf=1 or pointer already DEPTH.
- Undefined: no PAD state; unwritten memory keeps prior contents; LOAD goes directly to HOLD.

## Test plan
- Reset: drive rst=0 3 cycles mid-RUN → next cycle all outputs at reset values, core_rst=1, state IDLE.
- Load 4 words 0x1111..0x4444 back-to-back, last on 4th → imem_we high 4 consecutive cycles, addr 0..3, word_count=4, core_rst low exactly 10 cycles after HOLD entry.
- Halt: after release, hold core_pc=0x05 constant → done=1, done_reason=01 after 8 stable cycles; run_cycles matches elapsed count.
- Timeout: CYC_WIDTH=4, PC incrementing every cycle → done_reason=10 at run_cycles=15.
- Overflow: DEPTH=4, send 6 words no in_last → 4 writes, ovf=1, in_ready low after 4th, word_count=4.
- With LOADER_PAD_NOP_EN, DEPTH=8, load 3 words → 5 further writes of 0x0000 at addr 3..7, then HOLD.
